// File: rtl/alu_pkg.sv
// Shared definitions for the registered ALU: opcodes, flag bit positions,
// shift sub-op bits, multiplier FSM states and the adder overflow helper.
package alu_pkg;

    localparam logic [3:0] OP_ILLEGAL = 4'b0000;
    localparam logic [3:0] OP_AND     = 4'b0001;
    localparam logic [3:0] OP_OR      = 4'b0010;
    localparam logic [3:0] OP_XOR     = 4'b0011;
    localparam logic [3:0] OP_NOT     = 4'b0100;
    localparam logic [3:0] OP_ADD     = 4'b0101;
    localparam logic [3:0] OP_ADDU    = 4'b0110;
    localparam logic [3:0] OP_ADDC    = 4'b0111;
    localparam logic [3:0] OP_SHIFT   = 4'b1000;
    localparam logic [3:0] OP_SUB     = 4'b1001;
    localparam logic [3:0] OP_SUBC    = 4'b1010;
    localparam logic [3:0] OP_CMP     = 4'b1011;
    localparam logic [3:0] OP_MUL     = 4'b1100;
    localparam logic [3:0] OP_MOV     = 4'b1101;
    localparam logic [3:0] OP_MULS    = 4'b1110;
    localparam logic [3:0] OP_LU      = 4'b1111;

    localparam int FLG_C = 4;
    localparam int FLG_L = 3;
    localparam int FLG_F = 2;
    localparam int FLG_Z = 1;
    localparam int FLG_N = 0;

    // shmode[SHM_ARITH]: 1 = arithmetic; shmode[SHM_IMM]: 1 = amount from imm
    localparam int SHM_ARITH = 1;
    localparam int SHM_IMM   = 0;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_MUL_RUN = 2'b01,
        ST_MUL_FIX = 2'b10
    } mul_state_e;

    function automatic logic add_overflow(input logic a_msb, input logic b_msb, input logic r_msb);
        return (a_msb == b_msb) && (r_msb != a_msb);
    endfunction

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier working on operand magnitudes; the sign is
// applied in the final state. done/product are valid together for one cycle.
module alu_mul_iter
    import alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 abort,
    input  logic                 is_signed,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    mul_state_e           r_state;
    logic [CNT_W-1:0]     r_cnt;
    logic [WIDTH-1:0]     r_mcand;
    logic [2*WIDTH-1:0]   r_acc;
    logic                 r_neg;

    logic [WIDTH-1:0]     w_mag_a;
    logic [WIDTH-1:0]     w_mag_b;
    logic [WIDTH:0]       w_step;
    logic [2*WIDTH-1:0]   w_fix;

    // Operand magnitudes, one add step and the final sign correction
    always_comb begin
        if (is_signed && a[WIDTH-1]) begin
            w_mag_a = ~a + WIDTH'(1'b1);
        end else begin
            w_mag_a = a;
        end
        if (is_signed && b[WIDTH-1]) begin
            w_mag_b = ~b + WIDTH'(1'b1);
        end else begin
            w_mag_b = b;
        end
        if (r_acc[0]) begin
            w_step = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, r_mcand};
        end else begin
            w_step = {1'b0, r_acc[2*WIDTH-1:WIDTH]};
        end
        if (r_neg) begin
            w_fix = ~r_acc + (2*WIDTH)'(1'b1);
        end else begin
            w_fix = r_acc;
        end
    end

    assign done    = (r_state == ST_MUL_FIX) && !abort;
    assign product = w_fix;

    // Multiplier FSM: the low half of r_acc holds the shrinking multiplier
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= {CNT_W{1'b0}};
            r_mcand <= {WIDTH{1'b0}};
            r_acc   <= {(2*WIDTH){1'b0}};
            r_neg   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_mcand <= w_mag_a;
                        r_acc   <= {{WIDTH{1'b0}}, w_mag_b};
                        r_neg   <= is_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
                        r_cnt   <= {CNT_W{1'b0}};
                        r_state <= ST_MUL_RUN;
                    end
                end
                ST_MUL_RUN: begin
                    if (abort) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_acc <= {w_step, r_acc[WIDTH-1:1]};
                        r_cnt <= r_cnt + CNT_W'(1'b1);
                        if (r_cnt == CNT_W'(WIDTH - 1)) begin
                            r_state <= ST_MUL_FIX;
                        end
                    end
                end
                ST_MUL_FIX: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: rtl/alu_mc.sv
// Registered ALU with one-cycle single ops, an iterative multiplier and a
// CLFZN flag register whose carry feeds ADDC/SUBC without a bubble.
module alu_mc
    import alu_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int IMM_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [3:0]           op,
    input  logic [1:0]           shmode,
    input  logic [WIDTH-1:0]     dest,
    input  logic [WIDTH-1:0]     src,
    input  logic [IMM_WIDTH-1:0] imm,
    input  logic                 imm_en,
    input  logic                 abort,
    output logic                 ready,
    output logic                 out_valid,
    output logic [WIDTH-1:0]     result,
    output logic [WIDTH-1:0]     result_hi,
    output logic [4:0]           flags,
    output logic                 illegal
);

    localparam int SH_W = $clog2(WIDTH);

    logic                        r_ready;
    logic                        r_out_valid;
    logic                        r_illegal;
    logic                        r_mul_signed;
    logic [WIDTH-1:0]            r_result;
    logic [WIDTH-1:0]            r_result_hi;
    logic [4:0]                  r_flags;

    logic                        w_accept;
    logic                        w_is_mul;
    logic                        w_mul_start;
    logic                        w_mul_done;
    logic                        w_sext;
    logic                        w_is_sub;
    logic                        w_cin;
    logic                        w_ovf;
    logic                        w_illegal;
    logic                        w_shdir;
    logic                        w_mul_ovf;
    logic signed [IMM_WIDTH-1:0] w_imm_s;
    logic [WIDTH-1:0]            w_imm_zx;
    logic [WIDTH-1:0]            w_imm_sx;
    logic [WIDTH-1:0]            w_b;
    logic [WIDTH-1:0]            w_addend;
    logic [WIDTH-1:0]            w_res;
    logic [WIDTH-1:0]            w_sra;
    logic [WIDTH-1:0]            w_shres;
    logic [WIDTH-1:0]            w_mul_lo;
    logic [WIDTH-1:0]            w_mul_hi;
    logic [WIDTH:0]              w_sum;
    logic [SH_W-1:0]             w_shamt;
    logic [2*WIDTH-1:0]          w_product;
    logic [4:0]                  w_flags;
    logic [4:0]                  w_mul_flags;

    assign w_accept    = start && r_ready;
    assign w_is_mul    = (op == OP_MUL) || (op == OP_MULS);
    assign w_mul_start = w_accept && w_is_mul;

    // Operand B: src, or imm extended by zero or sign depending on the op class
    always_comb begin
        w_imm_s  = imm;
        w_imm_zx = WIDTH'(imm);
        w_imm_sx = WIDTH'(w_imm_s);
        case (op)
            OP_ADD, OP_ADDU, OP_ADDC, OP_SUB, OP_SUBC, OP_CMP, OP_MUL, OP_MULS: w_sext = 1'b1;
            default: w_sext = 1'b0;
        endcase
        if (!imm_en) begin
            w_b = src;
        end else if (w_sext) begin
            w_b = w_imm_sx;
        end else begin
            w_b = w_imm_zx;
        end
    end

    // Shared adder; subtraction is dest + ~B + carry-in
    always_comb begin
        w_is_sub = (op == OP_SUB) || (op == OP_SUBC) || (op == OP_CMP);
        w_addend = w_is_sub ? ~w_b : w_b;
        if ((op == OP_ADDC) || (op == OP_SUBC)) begin
            w_cin = r_flags[FLG_C];
        end else begin
            w_cin = w_is_sub;
        end
        w_sum = {1'b0, dest} + {1'b0, w_addend} + {{WIDTH{1'b0}}, w_cin};
        w_ovf = add_overflow(dest[WIDTH-1], w_addend[WIDTH-1], w_sum[WIDTH-1]);
    end

    // Barrel shifter; the arithmetic result is kept separate so it stays signed
    always_comb begin
        if (shmode[SHM_IMM]) begin
            w_shamt = imm[SH_W-1:0];
            w_shdir = imm[SH_W];
        end else begin
            w_shamt = src[SH_W-1:0];
            w_shdir = src[SH_W];
        end
        w_sra = $signed(dest) >>> w_shamt;
        if (!w_shdir) begin
            w_shres = dest << w_shamt;
        end else if (shmode[SHM_ARITH]) begin
            w_shres = w_sra;
        end else begin
            w_shres = dest >> w_shamt;
        end
    end

    // Single-cycle result and next flags
    always_comb begin
        w_res     = {WIDTH{1'b0}};
        w_flags   = r_flags;
        w_illegal = 1'b0;
        case (op)
            OP_AND, OP_OR, OP_XOR: begin
                if (op == OP_AND) begin
                    w_res = dest & w_b;
                end else if (op == OP_OR) begin
                    w_res = dest | w_b;
                end else begin
                    w_res = dest ^ w_b;
                end
                w_flags        = 5'b00000;
                w_flags[FLG_Z] = (w_res == {WIDTH{1'b0}});
            end
            OP_NOT: begin
                w_res   = ~dest;
                w_flags = 5'b00000;
            end
            OP_ADD, OP_ADDU, OP_ADDC, OP_SUB, OP_SUBC, OP_CMP: begin
                w_res          = w_sum[WIDTH-1:0];
                w_flags        = 5'b00000;
                w_flags[FLG_C] = w_sum[WIDTH];
                w_flags[FLG_L] = w_is_sub && (dest < w_b);
                w_flags[FLG_F] = w_ovf;
                w_flags[FLG_Z] = (w_sum[WIDTH-1:0] == {WIDTH{1'b0}});
                w_flags[FLG_N] = w_sum[WIDTH-1] ^ w_ovf;
            end
            OP_SHIFT: begin
                w_res          = w_shres;
                w_flags        = 5'b00000;
                w_flags[FLG_Z] = (w_shres == {WIDTH{1'b0}});
                w_flags[FLG_N] = w_shres[WIDTH-1];
            end
            OP_MOV: begin
                w_res = w_b;
            end
            OP_LU: begin
                w_res = w_b << (WIDTH / 2);
            end
            OP_MUL, OP_MULS: begin
                w_res = {WIDTH{1'b0}};
            end
            OP_ILLEGAL: begin
                w_illegal = 1'b1;
            end
            default: begin
                w_illegal = 1'b1;
            end
        endcase
    end

    // Multiply flags: overflow means the product does not fit in WIDTH bits
    always_comb begin
        w_mul_lo = w_product[WIDTH-1:0];
        w_mul_hi = w_product[2*WIDTH-1:WIDTH];
        if (r_mul_signed) begin
            w_mul_ovf = (w_mul_hi != {WIDTH{w_mul_lo[WIDTH-1]}});
        end else begin
            w_mul_ovf = (w_mul_hi != {WIDTH{1'b0}});
        end
        w_mul_flags        = 5'b00000;
        w_mul_flags[FLG_C] = w_mul_ovf;
        w_mul_flags[FLG_F] = w_mul_ovf;
        w_mul_flags[FLG_Z] = (w_product == {(2*WIDTH){1'b0}});
        w_mul_flags[FLG_N] = r_mul_signed && w_product[2*WIDTH-1];
    end

    alu_mul_iter #(
        .WIDTH     (WIDTH)
    ) u_mul (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (w_mul_start),
        .abort     (abort),
        .is_signed (op == OP_MULS),
        .a         (dest),
        .b         (w_b),
        .done      (w_mul_done),
        .product   (w_product)
    );

    // Output, flag and handshake registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ready      <= 1'b1;
            r_out_valid  <= 1'b0;
            r_illegal    <= 1'b0;
            r_mul_signed <= 1'b0;
            r_result     <= {WIDTH{1'b0}};
            r_result_hi  <= {WIDTH{1'b0}};
            r_flags      <= 5'b00000;
        end else begin
            r_out_valid <= 1'b0;
            r_illegal   <= 1'b0;
            if (w_mul_done) begin
                r_result    <= w_mul_lo;
                r_result_hi <= w_mul_hi;
                r_flags     <= w_mul_flags;
                r_out_valid <= 1'b1;
                r_ready     <= 1'b1;
            end else if (!r_ready) begin
                if (abort) begin
                    r_ready <= 1'b1;
                end
            end else if (w_mul_start) begin
                r_ready      <= 1'b0;
                r_mul_signed <= (op == OP_MULS);
            end else if (w_accept) begin
                r_result    <= w_res;
                r_result_hi <= {WIDTH{1'b0}};
                r_flags     <= w_flags;
                r_out_valid <= 1'b1;
                r_illegal   <= w_illegal;
            end
        end
    end

    assign ready     = r_ready;
    assign out_valid = r_out_valid;
    assign result    = r_result;
    assign result_hi = r_result_hi;
    assign flags     = r_flags;
    assign illegal   = r_illegal;

endmodule

// File: tb/tb_alu_mc.sv
// Randomised self-checking bench for alu_mc (WIDTH=16) against an
// integer-arithmetic reference model, plus the directed boundary cases.
module tb_alu_mc;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [3:0]  op;
    logic [1:0]  shmode;
    logic [15:0] dest;
    logic [15:0] src;
    logic [7:0]  imm;
    logic        imm_en;
    logic        abort;
    logic        ready;
    logic        out_valid;
    logic [15:0] result;
    logic [15:0] result_hi;
    logic [4:0]  flags;
    logic        illegal;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [4:0]  m_flags;

    alu_mc #(.WIDTH(16), .IMM_WIDTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .op        (op),
        .shmode    (shmode),
        .dest      (dest),
        .src       (src),
        .imm       (imm),
        .imm_en    (imm_en),
        .abort     (abort),
        .ready     (ready),
        .out_valid (out_valid),
        .result    (result),
        .result_hi (result_hi),
        .flags     (flags),
        .illegal   (illegal)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int s16(input logic [15:0] v);
        return int'($signed(v));
    endfunction

    // Reference: plain integer arithmetic on the architectural rules
    function automatic void ref_model(input logic [3:0] f_op, input logic [1:0] f_sh,
                                      input logic [15:0] f_dest, input logic [15:0] f_src,
                                      input logic [7:0] f_imm, input logic f_imm_en,
                                      input logic [4:0] f_fin,
                                      output logic [15:0] f_res, output logic [15:0] f_hi,
                                      output logic [4:0] f_fl, output logic f_ill);
        int a, b, nb, cin, sum, v, amt;
        bit sext, sgn, ovf;
        longint p;
        logic [31:0] p32;
        logic [15:0] sa;
        sext = f_op inside {4'd5, 4'd6, 4'd7, 4'd9, 4'd10, 4'd11, 4'd12, 4'd14};
        if (!f_imm_en) b = int'(f_src);
        else if (sext) b = int'($signed(f_imm)) & 32'hFFFF;
        else b = int'(f_imm);
        a = int'(f_dest);
        f_res = 16'h0000; f_hi = 16'h0000; f_fl = f_fin; f_ill = 1'b0;
        case (f_op)
            4'd1, 4'd2, 4'd3: begin
                if (f_op == 4'd1) f_res = 16'(a & b);
                else if (f_op == 4'd2) f_res = 16'(a | b);
                else f_res = 16'(a ^ b);
                f_fl = {3'b000, f_res == 16'h0000, 1'b0};
            end
            4'd4: begin f_res = ~f_dest; f_fl = 5'b00000; end
            4'd5, 4'd6, 4'd7: begin
                cin = (f_op == 4'd7) ? int'(f_fin[4]) : 0;
                sum = a + b + cin;
                f_res = 16'(sum);
                v = s16(f_dest) + s16(16'(b)) + cin;
                ovf = (v > 32767) || (v < -32768);
                f_fl = {sum > 65535, 1'b0, ovf, f_res == 16'h0000, f_res[15] ^ ovf};
            end
            4'd9, 4'd10, 4'd11: begin
                nb = (~b) & 32'hFFFF;
                cin = (f_op == 4'd10) ? int'(f_fin[4]) : 1;
                sum = a + nb + cin;
                f_res = 16'(sum);
                v = s16(f_dest) + s16(16'(nb)) + cin;
                ovf = (v > 32767) || (v < -32768);
                f_fl = {sum > 65535, a < b, ovf, f_res == 16'h0000, f_res[15] ^ ovf};
            end
            4'd8: begin
                sa = f_sh[0] ? {8'h00, f_imm} : f_src;
                amt = int'(sa[3:0]);
                if (!sa[4]) f_res = 16'(a << amt);
                else if (f_sh[1]) f_res = 16'(s16(f_dest) >>> amt);
                else f_res = 16'(a >> amt);
                f_fl = {3'b000, f_res == 16'h0000, f_res[15]};
            end
            4'd12, 4'd14: begin
                sgn = (f_op == 4'd14);
                if (sgn) p = longint'(s16(f_dest)) * longint'(s16(16'(b)));
                else p = longint'(a) * longint'(b);
                p32 = p[31:0];
                f_res = p32[15:0];
                f_hi = p32[31:16];
                ovf = sgn ? ((p > 32767) || (p < -32768)) : (p > 65535);
                f_fl = {ovf, 1'b0, ovf, p == 0, sgn && (p < 0)};
            end
            4'd13: f_res = 16'(b);
            4'd15: f_res = 16'(b << 8);
            default: f_ill = 1'b1;
        endcase
    endfunction

    task automatic check_reset_values(input string tag);
        check_eq({tag, "_ready"}, ready, 1);
        check_eq({tag, "_valid"}, out_valid, 0);
        check_eq({tag, "_illegal"}, illegal, 0);
        check_eq({tag, "_result"}, result, 0);
        check_eq({tag, "_result_hi"}, result_hi, 0);
        check_eq({tag, "_flags"}, flags, 0);
    endtask

    // Issue one op, wait for its result (bounded), compare with the model
    task automatic run_op(input logic [3:0] t_op, input logic [1:0] t_sh, input logic [15:0] t_dest,
                          input logic [15:0] t_src, input logic [7:0] t_imm, input logic t_imm_en);
        logic [15:0] e_res, e_hi;
        logic [4:0]  e_fl;
        logic        e_ill;
        int          n;
        ref_model(t_op, t_sh, t_dest, t_src, t_imm, t_imm_en, m_flags, e_res, e_hi, e_fl, e_ill);
        @(negedge clk);
        op = t_op; shmode = t_sh; dest = t_dest; src = t_src; imm = t_imm; imm_en = t_imm_en;
        abort = 1'($urandom_range(0, 1));
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        abort = 1'b0;
        if (t_op == 4'd12 || t_op == 4'd14) begin
            check_eq($sformatf("op%0d_ready_low", t_op), ready, 0);
            n = 0;
            while (!out_valid && n < 40) begin
                start = 1'($urandom_range(0, 1));
                op = 4'($urandom);
                dest = 16'($urandom);
                @(posedge clk); #1;
                n++;
            end
            start = 1'b0;
            check_eq($sformatf("op%0d_latency", t_op), n, 17);
        end
        check_eq($sformatf("op%0d_valid", t_op), out_valid, 1);
        check_eq($sformatf("op%0d_ready", t_op), ready, 1);
        check_eq($sformatf("op%0d_result", t_op), result, e_res);
        check_eq($sformatf("op%0d_result_hi", t_op), result_hi, e_hi);
        check_eq($sformatf("op%0d_flags", t_op), flags, e_fl);
        check_eq($sformatf("op%0d_illegal", t_op), illegal, e_ill);
        m_flags = e_fl;
    endtask

    // MUL 0x00FF x 0x0101 cut short by abort or reset at accept edge + cut_edge
    task automatic mul_cut(input int cut_edge, input bit use_reset, input string tag);
        logic seen;
        seen = 1'b0;
        @(negedge clk);
        op = 4'd12; dest = 16'h00FF; src = 16'h0101; imm_en = 1'b0; abort = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check_eq({tag, "_ready_low"}, ready, 0);
        repeat (cut_edge - 1) begin
            @(posedge clk); #1;
            seen |= out_valid;
        end
        @(negedge clk);
        if (use_reset) begin
            rst_n = 1'b0;
            #1;
            check_reset_values(tag);
            @(negedge clk);
            rst_n = 1'b1;
            m_flags = 5'b00000;
        end else begin
            abort = 1'b1;
            @(posedge clk); #1;
            abort = 1'b0;
            seen |= out_valid;
            check_eq({tag, "_ready_back"}, ready, 1);
            check_eq({tag, "_flags_kept"}, flags, m_flags);
        end
        repeat (20) begin
            @(posedge clk); #1;
            seen |= out_valid;
        end
        check_eq({tag, "_no_valid"}, seen, 0);
        check_eq({tag, "_flags_after"}, flags, m_flags);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] corner [6];
        logic [15:0] r_d, r_s;
        logic [3:0]  r_op;
        corner[0] = 16'h0000; corner[1] = 16'hFFFF; corner[2] = 16'h8000;
        corner[3] = 16'h7FFF; corner[4] = 16'h0001; corner[5] = 16'h00FF;
        rst_n = 1'b0; start = 1'b0; op = 4'h0; shmode = 2'b00; dest = 16'h0;
        src = 16'h0; imm = 8'h00; imm_en = 1'b0; abort = 1'b0; m_flags = 5'b00000;
        repeat (3) @(posedge clk);
        #1;
        check_reset_values("reset");
        @(negedge clk);
        rst_n = 1'b1;

        run_op(4'd5, 2'b00, 16'h7FFF, 16'h0001, 8'h00, 1'b0);
        check_eq("tp_add_ovf_res", result, 16'h8000);
        check_eq("tp_add_ovf_flags", flags, 5'b00100);
        run_op(4'd5, 2'b00, 16'hFFFF, 16'h0001, 8'h00, 1'b0);
        check_eq("tp_add_carry_res", result, 16'h0000);
        check_eq("tp_add_carry_flags", flags, 5'b10010);
        run_op(4'd7, 2'b00, 16'h0000, 16'h0000, 8'h00, 1'b0);
        check_eq("tp_addc_res", result, 16'h0001);
        run_op(4'd9, 2'b00, 16'h0005, 16'h1234, 8'hFF, 1'b1);
        check_eq("tp_sub_imm_res", result, 16'h0006);
        check_eq("tp_sub_imm_flags", flags, 5'b01000);
        run_op(4'd14, 2'b00, 16'hFFFD, 16'h0007, 8'h00, 1'b0);
        check_eq("tp_muls_lo", result, 16'hFFEB);
        check_eq("tp_muls_hi", result_hi, 16'hFFFF);
        check_eq("tp_muls_flags", flags, 5'b00001);
        run_op(4'd8, 2'b11, 16'h8000, 16'h0000, 8'h14, 1'b0);
        check_eq("tp_sra_res", result, 16'hF800);
        check_eq("tp_sra_flags", flags, 5'b00001);
        run_op(4'd0, 2'b00, 16'h1234, 16'h5678, 8'h00, 1'b0);
        check_eq("tp_illegal", illegal, 1);

        mul_cut(5, 1'b0, "abort_run");
        run_op(4'd5, 2'b00, 16'h1234, 16'h1111, 8'h00, 1'b0);
        check_eq("tp_add_after_abort", result, 16'h2345);
        mul_cut(17, 1'b0, "abort_fix");
        run_op(4'd9, 2'b00, 16'h0001, 16'h0002, 8'h00, 1'b0);
        mul_cut(5, 1'b1, "reset_run");
        run_op(4'd5, 2'b00, 16'h0003, 16'h0004, 8'h00, 1'b0);

        for (int i = 0; i < 300; i++) begin
            r_d  = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 5)] : 16'($urandom);
            r_s  = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 5)] : 16'($urandom);
            r_op = 4'($urandom);
            run_op(r_op, 2'($urandom), r_d, r_s, 8'($urandom), 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk); #1;
                check_eq("idle_valid_low", out_valid, 0);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/alu_mc.md
# alu_mc

Parametrised, registered successor to the combinational datapath ALU. Executes the existing opcode set at WIDTH bits with one-cycle latency. Adds a multi-cycle signed/unsigned multiply, an internal CLFZN flag register that feeds ADDC/SUBC, and a start/ready/out_valid handshake. It sits between the register-file read stage and the write-back stage of the CPU datapath.

## Interface
- WIDTH, 16: datapath width; must be ≥ 8 and a power of two.
- IMM_WIDTH, 8: immediate width; must be ≥ $clog2(WIDTH)+1.
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- start  in  1  request; accepted on an edge where start=1 and ready=1.
- op  in  4  opcode.
- shmode  in  2  shift sub-op: [1] 1 = arithmetic, 0 = logical; [0] 1 = amount from imm, 0 = amount from src.
- dest, src  in  WIDTH  operands.
- imm  in  IMM_WIDTH  immediate.
- imm_en  in  1  replace src with the extended imm.
- abort  in  1  synchronous cancel of an in-flight multiply.
- ready  out  1  can accept a request.
- out_valid  out  1  one-cycle pulse; result is valid.
- result  out  WIDTH  result, or the low product half.
- result_hi  out  WIDTH  high product half; 0 for non-multiply ops.
- flags  out  5  registered {C,L,F,Z,N}, bit 4 = C.
- illegal  out  1  one-cycle pulse with out_valid for an undefined op.

## Operation
- Opcodes: AND 0001, OR 0010, XOR 0011, NOT 0100, ADD 0101, ADDU 0110, ADDC 0111, SHIFT 1000, SUB 1001, SUBC 1010, CMP 1011, MUL 1100 (unsigned), MULS 1110 (signed), MOV 1101, LU 1111. 0000 is illegal.
- Operand B: src, or imm when imm_en=1. Extension is zero for AND/OR/XOR/MOV/LU and sign for ADD*/SUB*/CMP/MUL*.
- Logic ops: Z from result; C, L, F and N are cleared. NOT: result = ~dest; all flags cleared.
- ADD/ADDU/ADDC: {C,result} = dest+B(+flags.C for ADDC). F is two's-complement overflow. Z as usual. N = result[MSB]^F.
- SUB/SUBC/CMP: {C,result} = dest+~B+(SUBC ? flags.C : 1). L = unsigned dest < B. F, Z and N are computed as for add.
- CMP updates flags and drives the result, but the result is marked discard (write-back ignores it).
- MOV: result = B. LU: result = B << (WIDTH/2). Both leave flags unchanged.
- SHIFT: amount = A[$clog2(WIDTH)-1:0], direction = A[$clog2(WIDTH)] (1 = right), where A is imm or src per shmode[0]. Arithmetic-right replicates the MSB; left shifts are identical for both modes. Z and N come from the result; C, L and F are cleared.
- MUL/MULS: {result_hi,result} = full 2·WIDTH product, computed one bit per cycle by shift-add on magnitudes. The sign is applied in the final cycle.
  - Z: product == 0.
  - N: product MSB (MULS only; 0 for MUL).
  - C = F = product does not fit in WIDTH (unsigned: hi≠0; signed: hi is not the sign extension of the low half).
  - L: cleared.
- Illegal op: result 0, flags unchanged, illegal pulses.
- FSM states: IDLE, MUL_RUN, MUL_FIX.
  - IDLE→MUL_RUN on an accepted MUL/MULS.
  - MUL_RUN runs WIDTH iterations, counted by a $clog2(WIDTH)+1-bit counter, then →MUL_FIX.
  - MUL_FIX applies the sign, pulses out_valid and returns →IDLE.
  - abort in MUL_RUN or MUL_FIX →IDLE with no out_valid and no flag write.

## Timing
- Reset values: ready 1, out_valid 0, illegal 0, result 0, result_hi 0, flags 5'b00000, state IDLE.
- Single-cycle ops: accepted at edge T; result, flags and out_valid are registered at T+1. ready stays 1, so back-to-back issue is allowed.
- ADDC/SUBC issued the cycle after the producing op see the updated flags.C; there is no bubble.
- Multiply:
  - Accepted at edge T; ready=0 from T+1.
  - out_valid and result at edge T+WIDTH+1.
  - ready returns to 1 in that same cycle.
- start while ready=0 is ignored and has no effect.
- abort in IDLE has no effect. abort coinciding with the final MUL_FIX edge wins: no out_valid.
- rst_n low at any time, including mid-multiply, forces all reset values immediately.

## Structure
- Package alu_pkg holds: opcode localparams, flag bit indices (C=4, L=3, F=2, Z=1, N=0), shmode bit meanings and the FSM state enum.
- Sub-module alu_mul_iter is the iterative multiplier. It contains the counter, partial-product/multiplier registers and the sign fix. Its interface is start/abort/signed in and done/product out.
- The top level holds the single-cycle combinational datapath, the flag register and the output registers.

## Test plan
- ADD 0x7FFF+0x0001 → result 0x8000, flags 5'b00100, out_valid at T+1.
- ADD 0xFFFF+0x0001, then ADDC 0x0000+0x0000 on the next cycle → 0x0000 with flags 5'b10010, then 0x0001.
- SUB dest=0x0005, imm=0xFF, imm_en=1 → result 0x0006, flags 5'b01000.
- MULS 0xFFFD×0x0007 → result 0xFFEB, result_hi 0xFFFF, flags 5'b00001. ready=0 from T+1, out_valid exactly at T+17.
- SHIFT shmode=2'b11, imm=0x14, dest=0x8000 → result 0xF800, flags 5'b00001.
- Abort and reset mid-multiply:
  - MUL 0x00FF×0x0101 with abort at T+5 → no out_valid, flags unchanged, ready=1 at T+6. A following ADD completes normally.
  - Repeat with rst_n pulsed low instead of abort → all reset values.
